// File: rtl/s_spi_slave_sync_if.sv
// Pin-side and message-buffer-side signals of the SPI slave front end.
// The slave modport is the DUT view; the master modport drives the pins and tx_data.
interface s_spi_slave_sync_if #(
  parameter int DATA_W = 8
);
  logic              SCLK;
  logic              MOSI;
  logic              SS;
  logic              MISO;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_req;
  logic              busy;
  logic              frame_abort;

  modport slave (
    input  SCLK, MOSI, SS, tx_data,
    output MISO, rx_data, rx_valid, tx_req, busy, frame_abort
  );

  modport master (
    output SCLK, MOSI, SS, tx_data,
    input  MISO, rx_data, rx_valid, tx_req, busy, frame_abort
  );
endinterface

// File: rtl/s_spi_slave_sync.sv
// Mode-0 SPI slave front end, oversampled in the clk domain.
// Pins are synchronised, edges are registered, and a two-state FSM produces single-cycle strobes.
module s_spi_slave_sync #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_btn,
  s_spi_slave_sync_if.slave      bus
);
  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic [SYNC_STAGES-1:0] ss_sync_r;
  logic                   sclk_prev_r;
  logic                   ss_prev_r;
  logic                   rise_r;
  logic                   fall_r;
  logic                   ss_fall_r;
  logic                   ss_rise_r;
  logic                   mosi_r;
  logic                   sclk_s;
  logic                   ss_s;

  state_t                 state_r;
  logic [CNT_W-1:0]       bit_cnt_r;
  logic [DATA_W-2:0]      rx_shift_r;
  logic [DATA_W-1:0]      tx_shift_r;
  logic [DATA_W-1:0]      rx_data_r;
  logic                   rx_valid_r;
  logic                   tx_req_r;
  logic                   busy_r;
  logic                   frame_abort_r;
  logic                   skip_fall_r;

  assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
  assign ss_s   = ss_sync_r[SYNC_STAGES-1];

  // Pin synchronisers, reset to the idle bus state.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      sclk_sync_r <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      ss_sync_r   <= {SYNC_STAGES{1'b1}};
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], bus.SCLK};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], bus.MOSI};
      ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], bus.SS};
    end
  end

  // Registered edge detection; MOSI is delayed alongside so it lines up with rise_r.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      sclk_prev_r <= 1'b0;
      ss_prev_r   <= 1'b1;
      rise_r      <= 1'b0;
      fall_r      <= 1'b0;
      ss_fall_r   <= 1'b0;
      ss_rise_r   <= 1'b0;
      mosi_r      <= 1'b0;
    end else begin
      sclk_prev_r <= sclk_s;
      ss_prev_r   <= ss_s;
      rise_r      <= sclk_s & ~sclk_prev_r;
      fall_r      <= ~sclk_s & sclk_prev_r;
      ss_fall_r   <= ~ss_s & ss_prev_r;
      ss_rise_r   <= ss_s & ~ss_prev_r;
      mosi_r      <= mosi_sync_r[SYNC_STAGES-1];
    end
  end

  // Frame FSM; tx_shift is held at zero outside a frame so MISO idles low.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state_r       <= IDLE;
      bit_cnt_r     <= {CNT_W{1'b0}};
      rx_shift_r    <= {(DATA_W-1){1'b0}};
      tx_shift_r    <= {DATA_W{1'b0}};
      rx_data_r     <= {DATA_W{1'b0}};
      rx_valid_r    <= 1'b0;
      tx_req_r      <= 1'b0;
      busy_r        <= 1'b0;
      frame_abort_r <= 1'b0;
      skip_fall_r   <= 1'b0;
    end else begin
      rx_valid_r    <= 1'b0;
      tx_req_r      <= 1'b0;
      frame_abort_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (ss_fall_r) begin
            state_r     <= ACTIVE;
            tx_shift_r  <= bus.tx_data;
            tx_req_r    <= 1'b1;
            bit_cnt_r   <= {CNT_W{1'b0}};
            busy_r      <= 1'b1;
            skip_fall_r <= 1'b0;
          end else begin
            tx_shift_r  <= {DATA_W{1'b0}};
            busy_r      <= 1'b0;
          end
        end
        ACTIVE: begin
          if (ss_rise_r) begin
            state_r       <= IDLE;
            busy_r        <= 1'b0;
            frame_abort_r <= (bit_cnt_r != {CNT_W{1'b0}});
            bit_cnt_r     <= {CNT_W{1'b0}};
            tx_shift_r    <= {DATA_W{1'b0}};
            skip_fall_r   <= 1'b0;
          end else if (rise_r) begin
            rx_shift_r <= {rx_shift_r[DATA_W-3:0], mosi_r};
            if (bit_cnt_r == LAST_BIT) begin
              rx_data_r   <= {rx_shift_r, mosi_r};
              rx_valid_r  <= 1'b1;
              tx_shift_r  <= bus.tx_data;
              tx_req_r    <= 1'b1;
              bit_cnt_r   <= {CNT_W{1'b0}};
              skip_fall_r <= 1'b1;
            end else begin
              bit_cnt_r   <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else if (fall_r) begin
            // The fall that ends a word must not shift away the new word's MSB.
            if (skip_fall_r) begin
              skip_fall_r <= 1'b0;
            end else begin
              tx_shift_r  <= {tx_shift_r[DATA_W-2:0], 1'b0};
            end
          end else begin
            skip_fall_r <= skip_fall_r;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MISO        = tx_shift_r[DATA_W-1];
  assign bus.rx_data     = rx_data_r;
  assign bus.rx_valid    = rx_valid_r;
  assign bus.tx_req      = tx_req_r;
  assign bus.busy        = busy_r;
  assign bus.frame_abort = frame_abort_r;
endmodule

// File: tb/tb_s_spi_slave_sync.sv
// Self-checking bench for s_spi_slave_sync: scoreboard of expected rx words plus per-scenario checks.
module tb_s_spi_slave_sync;
  localparam int HALF = 8;

  logic clk;
  logic rst_btn;
  s_spi_slave_sync_if #(.DATA_W(8)) bus();

  s_spi_slave_sync #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst_btn (rst_btn),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         chk_cnt   = 0;
  int         pass_cnt  = 0;
  int         rx_cnt    = 0;
  int         txreq_cnt = 0;
  int         abort_cnt = 0;
  int         busy_drop = 0;
  logic       inc_mode  = 1'b0;
  logic [7:0] exp_q[$];

  // Monitor: scoreboard on rx_valid, event counters, and tx_data advance on tx_req.
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      rx_cnt++;
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL rx_unexpected: got rx_data=%h, expected no rx_valid", bus.rx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.rx_data !== e) $display("FAIL rx_data: got %h expected %h", bus.rx_data, e);
        else pass_cnt++;
      end
    end
    if (bus.tx_req === 1'b1) begin
      txreq_cnt++;
      if (inc_mode) bus.tx_data = bus.tx_data + 8'd1;
    end
    if (bus.frame_abort === 1'b1) abort_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired, expected completion");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.MOSI = mo[i];
      wait_clk(HALF);
      mi[i] = bus.MISO;
      if (bus.busy !== 1'b1) busy_drop++;
      bus.SCLK = 1'b1;
      wait_clk(HALF);
      bus.SCLK = 1'b0;
    end
  endtask

  task automatic ss_begin();
    bus.SS = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic ss_end();
    wait_clk(HALF);
    bus.SS = 1'b1;
    wait_clk(12);
  endtask

  task automatic test_reset();
    rst_btn = 1'b0;
    bus.SS = 1'b1; bus.SCLK = 1'b0; bus.MOSI = 1'b0; bus.tx_data = 8'h00;
    wait_clk(4);
    chk_cnt++; if (bus.MISO !== 1'b0) $display("FAIL reset_miso: got %b expected 0", bus.MISO); else pass_cnt++;
    chk_cnt++; if (bus.rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", bus.rx_data); else pass_cnt++;
    chk_cnt++;
    if ({bus.rx_valid, bus.tx_req, bus.busy, bus.frame_abort} !== 4'b0000)
      $display("FAIL reset_strobes: got %b expected 0000", {bus.rx_valid, bus.tx_req, bus.busy, bus.frame_abort});
    else pass_cnt++;
    rst_btn = 1'b1;
    wait_clk(6);
  endtask

  task automatic test_single();
    logic [7:0] mi;
    int rx0, tq0, ab0;
    rx0 = rx_cnt; tq0 = txreq_cnt; ab0 = abort_cnt; busy_drop = 0;
    bus.tx_data = 8'h53;
    exp_q.push_back(8'hA5);
    ss_begin();
    send_bits(8'hA5, 8, mi);
    ss_end();
    chk_cnt++; if (mi !== 8'h53) $display("FAIL single_miso: got %h expected 53", mi); else pass_cnt++;
    chk_cnt++; if (rx_cnt - rx0 !== 1) $display("FAIL single_rx_count: got %0d expected 1", rx_cnt - rx0); else pass_cnt++;
    chk_cnt++; if (txreq_cnt - tq0 !== 2) $display("FAIL single_tx_req: got %0d expected 2", txreq_cnt - tq0); else pass_cnt++;
    chk_cnt++; if (bus.rx_data !== 8'hA5) $display("FAIL single_rx_data: got %h expected a5", bus.rx_data); else pass_cnt++;
    chk_cnt++; if (abort_cnt - ab0 !== 0) $display("FAIL single_abort: got %0d expected 0", abort_cnt - ab0); else pass_cnt++;
  endtask

  task automatic test_multi();
    logic [7:0] mi[3];
    logic [7:0] mo[3] = '{8'h01, 8'h02, 8'h03};
    logic [7:0] ex[3] = '{8'h4C, 8'h4D, 8'h4E};
    int rx0, tq0;
    rx0 = rx_cnt; tq0 = txreq_cnt; busy_drop = 0;
    bus.tx_data = 8'h4C;
    inc_mode = 1'b1;
    ss_begin();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mo[k]);
      send_bits(mo[k], 8, mi[k]);
    end
    ss_end();
    inc_mode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_cnt++;
      if (mi[k] !== ex[k]) $display("FAIL multi_miso%0d: got %h expected %h", k, mi[k], ex[k]); else pass_cnt++;
    end
    chk_cnt++; if (rx_cnt - rx0 !== 3) $display("FAIL multi_rx_count: got %0d expected 3", rx_cnt - rx0); else pass_cnt++;
    chk_cnt++; if (txreq_cnt - tq0 !== 4) $display("FAIL multi_tx_req: got %0d expected 4", txreq_cnt - tq0); else pass_cnt++;
    chk_cnt++; if (busy_drop !== 0) $display("FAIL multi_busy: busy low %0d times, expected 0", busy_drop); else pass_cnt++;
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    int rx0, ab0;
    rx0 = rx_cnt; ab0 = abort_cnt;
    ss_begin();
    send_bits(8'hF0, 5, mi);
    ss_end();
    chk_cnt++; if (abort_cnt - ab0 !== 1) $display("FAIL abort_pulse: got %0d expected 1", abort_cnt - ab0); else pass_cnt++;
    chk_cnt++; if (rx_cnt - rx0 !== 0) $display("FAIL abort_rx: got %0d expected 0", rx_cnt - rx0); else pass_cnt++;
    chk_cnt++; if (bus.rx_data !== 8'h03) $display("FAIL abort_rx_data: got %h expected 03", bus.rx_data); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", bus.busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] mi;
    int rx0;
    bus.tx_data = 8'hFF;
    ss_begin();
    send_bits(8'hFF, 3, mi);
    bus.SCLK = 1'b1;
    wait_clk(HALF);
    rst_btn = 1'b0;
    #1;
    chk_cnt++;
    if ({bus.MISO, bus.rx_valid, bus.tx_req, bus.busy, bus.frame_abort} !== 5'b00000 || bus.rx_data !== 8'h00)
      $display("FAIL midreset_outputs: got %b/%h expected 00000/00",
               {bus.MISO, bus.rx_valid, bus.tx_req, bus.busy, bus.frame_abort}, bus.rx_data);
    else pass_cnt++;
    wait_clk(3);
    bus.SS = 1'b1; bus.SCLK = 1'b0; bus.MOSI = 1'b0;
    wait_clk(2);
    rst_btn = 1'b1;
    wait_clk(6);
    rx0 = rx_cnt;
    exp_q.push_back(8'hFF);
    ss_begin();
    send_bits(8'hFF, 8, mi);
    ss_end();
    chk_cnt++; if (bus.rx_data !== 8'hFF) $display("FAIL midreset_new_frame: got %h expected ff", bus.rx_data); else pass_cnt++;
    chk_cnt++; if (rx_cnt - rx0 !== 1) $display("FAIL midreset_rx_count: got %0d expected 1", rx_cnt - rx0); else pass_cnt++;
  endtask

  task automatic test_idle_noise();
    int rx0, tq0, ab0, miso_hi;
    rx0 = rx_cnt; tq0 = txreq_cnt; ab0 = abort_cnt; miso_hi = 0;
    bus.SS = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.MOSI = 1'($urandom_range(1, 0));
      bus.SCLK = ~bus.SCLK;
      wait_clk(4);
      if (bus.MISO !== 1'b0) miso_hi++;
    end
    bus.SCLK = 1'b0;
    wait_clk(8);
    chk_cnt++;
    if ((rx_cnt - rx0) + (txreq_cnt - tq0) + (abort_cnt - ab0) !== 0)
      $display("FAIL idle_strobes: got rx=%0d txreq=%0d abort=%0d expected 0/0/0",
               rx_cnt - rx0, txreq_cnt - tq0, abort_cnt - ab0);
    else pass_cnt++;
    chk_cnt++; if (miso_hi !== 0) $display("FAIL idle_miso: MISO high %0d samples, expected 0", miso_hi); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] mi0, mi1;
    int rx0, ab0;
    rx0 = rx_cnt; ab0 = abort_cnt;
    bus.tx_data = 8'h96;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    ss_begin();
    send_bits(8'h3C, 8, mi0);
    wait_clk(HALF);
    bus.SS = 1'b1;
    wait_clk(1);
    bus.SS = 1'b0;
    wait_clk(HALF);
    send_bits(8'hC3, 8, mi1);
    ss_end();
    chk_cnt++; if (rx_cnt - rx0 !== 2) $display("FAIL b2b_rx_count: got %0d expected 2", rx_cnt - rx0); else pass_cnt++;
    chk_cnt++; if (abort_cnt - ab0 !== 0) $display("FAIL b2b_abort: got %0d expected 0", abort_cnt - ab0); else pass_cnt++;
    chk_cnt++; if (mi1 !== 8'h96) $display("FAIL b2b_miso2: got %h expected 96", mi1); else pass_cnt++;
    chk_cnt++; if (bus.rx_data !== 8'hC3) $display("FAIL b2b_rx_data: got %h expected c3", bus.rx_data); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_abort();
    test_reset_mid();
    test_idle_noise();
    test_back_to_back();
    wait_clk(4);
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d words pending, expected 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
